// File: rtl/act_serializer.sv
// act_serializer: turns activation frames into a stream of bit-planes for a bit-serial PE array.
// A frame holds peSize activations of inputPrecision bits each. Planes go out LSB first, one per
// pe_valid_o rising edge, with a one-cycle low gap between consecutive planes. A one-deep pending
// buffer lets the next frame be accepted while the current frame is being serialized.
//
// Ports:
//   clk           clock, all state changes on its rising edge
//   nrst          asynchronous active-low reset
//   acts_valid_i  a frame is offered on acts_data_i
//   acts_ready_o  a frame can be accepted this cycle (registered, = pending buffer empty)
//   acts_data_i   frame; activation i at [i*inputPrecision +: inputPrecision]
//   pe_valid_o    a bit-plane is presented on pe_data_o
//   pe_data_o     bit-plane: bit i = bit pe_bit_idx_o of activation i
//   pe_done_i     PE has consumed the presented plane (level held past one edge is ignored)
//   pe_bit_idx_o  index of the presented plane
//   pe_last_o     the presented plane is the MSB plane
//   frame_done_o  one-cycle pulse after the MSB plane of a frame is consumed
module act_serializer #(
   parameter int unsigned peSize         = 1024,
   parameter int unsigned inputPrecision = 4,
   localparam int unsigned IdxW = (inputPrecision > 1) ? $clog2(inputPrecision) : 1
) (
   input  logic                               clk,
   input  logic                               nrst,
   input  logic                               acts_valid_i,
   output logic                               acts_ready_o,
   input  logic [peSize*inputPrecision-1:0]   acts_data_i,
   output logic                               pe_valid_o,
   output logic [peSize-1:0]                  pe_data_o,
   input  logic                               pe_done_i,
   output logic [IdxW-1:0]                    pe_bit_idx_o,
   output logic                               pe_last_o,
   output logic                               frame_done_o
);

   localparam int unsigned FrameW = peSize * inputPrecision;
   localparam logic [IdxW-1:0] LastIdx = IdxW'(inputPrecision - 1);

   typedef enum logic [1:0] {StIdle, StSend, StGap} state_e;

   state_e              state_q, state_d;
   logic [FrameW-1:0]   active_q, active_d;
   logic [FrameW-1:0]   pending_q, pending_d;
   logic                pend_full_q, pend_full_d;
   logic [IdxW-1:0]     idx_q, idx_d;
   logic                done_hold_q, done_hold_d;
   logic                ready_q, ready_d;
   logic                valid_q, valid_d;
   logic [peSize-1:0]   data_q, data_d;
   logic [IdxW-1:0]     bit_idx_q, bit_idx_d;
   logic                last_q, last_d;
   logic                frame_done_q, frame_done_d;

   logic                xfer;
   logic                consume;
   logic                frame_end;
   logic                active_free;
   logic [peSize-1:0]   plane;

   always_comb begin
      xfer        = acts_valid_i & ready_q;
      // A done level still high from the previous consuming edge must not consume again.
      consume     = (state_q == StSend) & pe_done_i & ~done_hold_q;
      frame_end   = consume & (idx_q == LastIdx);
      active_free = (state_q == StIdle) | (frame_end & ~pend_full_q);

      state_d      = state_q;
      active_d     = active_q;
      pending_d    = pending_q;
      pend_full_d  = pend_full_q;
      idx_d        = idx_q;
      frame_done_d = 1'b0;
      done_hold_d  = pe_done_i & (consume | done_hold_q);

      if (xfer && !active_free) begin
         pending_d   = acts_data_i;
         pend_full_d = 1'b1;
      end

      unique case (state_q)
         StIdle: begin
            if (xfer) begin
               active_d = acts_data_i;
               idx_d    = '0;
               state_d  = StSend;
            end
         end
         StSend: begin
            if (consume) begin
               if (!frame_end) begin
                  idx_d   = idx_q + IdxW'(1);
                  state_d = StGap;
               end else begin
                  frame_done_d = 1'b1;
                  idx_d        = '0;
                  if (pend_full_q) begin
                     active_d    = pending_q;
                     pending_d   = '0;
                     pend_full_d = 1'b0;
                     state_d     = StGap;
                  end else if (xfer) begin
                     active_d = acts_data_i;
                     state_d  = StGap;
                  end else begin
                     state_d = StIdle;
                  end
               end
            end
         end
         StGap: begin
            state_d = StSend;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      ready_d = ~pend_full_d;

      // Outputs are registered from next-state so they line up with the state they describe.
      plane = '0;
      for (int i = 0; i < int'(peSize); i++) begin
         plane[i] = active_d[i*int'(inputPrecision) + int'(idx_d)];
      end
      valid_d   = (state_d == StSend);
      data_d    = valid_d ? plane : '0;
      bit_idx_d = valid_d ? idx_d : '0;
      last_d    = valid_d & (idx_d == LastIdx);
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q      <= StIdle;
         active_q     <= '0;
         pending_q    <= '0;
         pend_full_q  <= 1'b0;
         idx_q        <= '0;
         done_hold_q  <= 1'b0;
         ready_q      <= 1'b0;
         valid_q      <= 1'b0;
         data_q       <= '0;
         bit_idx_q    <= '0;
         last_q       <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         active_q     <= active_d;
         pending_q    <= pending_d;
         pend_full_q  <= pend_full_d;
         idx_q        <= idx_d;
         done_hold_q  <= done_hold_d;
         ready_q      <= ready_d;
         valid_q      <= valid_d;
         data_q       <= data_d;
         bit_idx_q    <= bit_idx_d;
         last_q       <= last_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign acts_ready_o = ready_q;
   assign pe_valid_o   = valid_q;
   assign pe_data_o    = data_q;
   assign pe_bit_idx_o = bit_idx_q;
   assign pe_last_o    = last_q;
   assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_act_serializer.sv
// Bench for act_serializer (peSize=4, inputPrecision=4). A queue-based reference model turns every
// accepted frame into its expected bit-planes and tracks frames held by the block; a monitor
// compares the DUT against it after every clock edge. A PE model answers each plane with pe_done_i.
module tb_act_serializer;

   localparam int unsigned PeSize = 4;
   localparam int unsigned Prec   = 4;
   localparam int unsigned W      = PeSize * Prec;
   localparam int unsigned IdxW   = 2;

   logic              clk = 1'b0;
   logic              nrst = 1'b0;
   logic              acts_valid_i = 1'b0;
   logic              acts_ready_o;
   logic [W-1:0]      acts_data_i = '0;
   logic              pe_valid_o;
   logic [PeSize-1:0] pe_data_o;
   logic              pe_done_i = 1'b0;
   logic [IdxW-1:0]   pe_bit_idx_o;
   logic              pe_last_o;
   logic              frame_done_o;

   act_serializer #(
      .peSize         (PeSize),
      .inputPrecision (Prec)
   ) dut (
      .clk          (clk),
      .nrst         (nrst),
      .acts_valid_i (acts_valid_i),
      .acts_ready_o (acts_ready_o),
      .acts_data_i  (acts_data_i),
      .pe_valid_o   (pe_valid_o),
      .pe_data_o    (pe_data_o),
      .pe_done_i    (pe_done_i),
      .pe_bit_idx_o (pe_bit_idx_o),
      .pe_last_o    (pe_last_o),
      .frame_done_o (frame_done_o)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [PeSize-1:0] bits;
      int                idx;
   } plane_t;

   plane_t            exp_q[$];
   plane_t            cur;
   bit                cur_active = 0;
   int                phase = 0;       // 1: the previous edge consumed a plane
   int                n_frames = 0;    // frames held by the block (active + pending)
   bit                pd_prev = 0;
   int                fd_count = 0;
   int                plane_log[$];
   int                exp_log[$];

   function automatic logic [PeSize-1:0] plane_of(input logic [W-1:0] d, input int b);
      logic [PeSize-1:0] r;
      for (int i = 0; i < int'(PeSize); i++) r[i] = d[i*Prec + b];
      return r;
   endfunction

   task automatic model_clear();
      exp_q.delete();
      cur_active = 0;
      phase      = 0;
      n_frames   = 0;
      pd_prev    = 0;
   endtask

   always @(posedge clk) begin
      logic          pv, pd, rdy, av;
      logic [W-1:0]  ad;
      bit            consume, accept, was_idle, act_before, exp_fd;
      int            phase_before;
      if (nrst) begin
         pv = pe_valid_o; pd = pe_done_i; rdy = acts_ready_o; av = acts_valid_i; ad = acts_data_i;
         #1;
         if (nrst) begin
            consume      = pv && pd && !pd_prev;
            accept       = av && rdy;
            act_before   = cur_active;
            phase_before = phase;
            was_idle     = !act_before && phase_before == 0;
            pd_prev      = pd;
            phase        = consume ? 1 : 0;
            exp_fd       = 0;
            if (consume && cur_active) begin
               cur_active = 0;
               if (cur.idx == int'(Prec) - 1) begin
                  exp_fd = 1;
                  n_frames--;
               end
            end
            if (accept) begin
               for (int b = 0; b < int'(Prec); b++) begin
                  plane_t p;
                  p.bits = plane_of(ad, b);
                  p.idx  = b;
                  exp_q.push_back(p);
               end
               n_frames++;
            end
            check_eq("frame_done", frame_done_o, exp_fd);
            if (frame_done_o) fd_count++;
            check_eq("acts_ready", acts_ready_o, n_frames < 2);
            if (consume) check_eq("gap_low", pe_valid_o, 0);
            else if (phase_before == 1) check_eq("gap_then_send", pe_valid_o, exp_q.size() > 0);
            else if (was_idle) check_eq("idle_valid", pe_valid_o, accept);
            if (cur_active) begin
               check_eq("hold_valid", pe_valid_o, 1);
               check_eq("hold_data", pe_data_o, cur.bits);
               check_eq("hold_idx", pe_bit_idx_o, cur.idx);
            end else if (pe_valid_o) begin
               if (exp_q.size() == 0) begin
                  check_eq("spurious_plane", pe_valid_o, 0);
               end else begin
                  cur = exp_q.pop_front();
                  cur_active = 1;
                  plane_log.push_back(int'(pe_data_o));
                  check_eq("plane_data", pe_data_o, cur.bits);
                  check_eq("plane_idx", pe_bit_idx_o, cur.idx);
                  check_eq("plane_last", pe_last_o, cur.idx == int'(Prec) - 1);
               end
            end else begin
               check_eq("low_data", pe_data_o, 0);
               check_eq("low_idx", pe_bit_idx_o, 0);
               check_eq("low_last", pe_last_o, 0);
            end
         end
      end
   end

   // ---------------- PE model ----------------
   int pe_delay = 3;
   int done_len = 1;
   int wcnt = 0;
   int dleft = 0;
   bit vprev = 0;

   always @(negedge clk) begin
      if (!nrst) begin
         pe_done_i = 1'b0;
         wcnt = 0; dleft = 0; vprev = 0;
      end else begin
         if (dleft > 0) begin
            pe_done_i = 1'b1;
            dleft--;
         end else begin
            pe_done_i = 1'b0;
         end
         if (pe_valid_o && !vprev) begin
            wcnt = pe_delay;
         end else if (wcnt > 0) begin
            wcnt--;
            if (wcnt == 0) begin
               pe_done_i = 1'b1;
               dleft = done_len - 1;
            end
         end
         vprev = pe_valid_o;
      end
   end

   // ---------------- stimulus ----------------
   // Called just after a falling edge; returns just after the falling edge following acceptance.
   task automatic offer(input logic [W-1:0] d);
      int t = 0;
      acts_valid_i = 1'b1;
      acts_data_i  = d;
      while (!acts_ready_o && t < 3000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 3000) check_eq("offer_timeout", 1, 0);
      @(negedge clk);
      acts_valid_i = 1'b0;
      acts_data_i  = W'($urandom);
   endtask

   task automatic wait_idle();
      int t = 0;
      while (!(exp_q.size() == 0 && !cur_active && phase == 0 && !pe_valid_o) && t < 3000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 3000) check_eq("idle_timeout", 1, 0);
      repeat (2) @(negedge clk);
   endtask

   task automatic compare_log(input string tag);
      check_eq({tag, "_count"}, plane_log.size(), exp_log.size());
      for (int i = 0; i < exp_log.size() && i < plane_log.size(); i++)
         check_eq(tag, plane_log[i], exp_log[i]);
   endtask

   task automatic wait_plane(input int idx);
      int t = 0;
      while (!(pe_valid_o && int'(pe_bit_idx_o) == idx) && t < 1000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 1000) check_eq("wait_plane_timeout", 1, 0);
   endtask

   initial begin
      int fd0;
      logic [PeSize-1:0] d0;
      logic [W-1:0] b_frame;

      // Reset state
      nrst = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("rst_ready", acts_ready_o, 0);
      check_eq("rst_valid", pe_valid_o, 0);
      check_eq("rst_data", pe_data_o, 0);
      check_eq("rst_fd", frame_done_o, 0);
      nrst = 1'b1;
      @(posedge clk);
      #2;
      check_eq("ready_after_reset", acts_ready_o, 1);
      @(negedge clk);

      // Single frame
      plane_log.delete(); fd0 = fd_count;
      offer(16'h0FA3);
      wait_idle();
      exp_log = '{5, 7, 4, 6};
      compare_log("single_planes");
      check_eq("single_fd", fd_count - fd0, 1);

      // Back-to-back: second frame accepted during plane 1
      plane_log.delete(); fd0 = fd_count;
      offer(16'h0FA3);
      wait_plane(1);
      offer(16'hFFFF);
      #2;
      check_eq("b2b_ready_low", acts_ready_o, 0);
      wait_idle();
      exp_log = '{5, 7, 4, 6, 15, 15, 15, 15};
      compare_log("b2b_planes");
      check_eq("b2b_fd", fd_count - fd0, 2);

      // Backpressure: three frames offered continuously
      plane_log.delete(); fd0 = fd_count;
      offer(16'h1234);
      offer(16'h8421);
      offer(16'hC3A5);
      wait_idle();
      check_eq("bp_fd", fd_count - fd0, 3);
      check_eq("bp_planes", plane_log.size(), 12);

      // Stall: done withheld 50 cycles
      pe_delay = 50;
      offer(16'h5A69);
      wait_plane(0);
      d0 = pe_data_o;
      repeat (40) @(negedge clk);
      check_eq("stall_valid", pe_valid_o, 1);
      check_eq("stall_data", pe_data_o, d0);
      check_eq("stall_idx", pe_bit_idx_o, 0);
      wait_idle();
      pe_delay = 3;

      // Held done level: each plane consumed exactly once
      plane_log.delete(); fd0 = fd_count;
      done_len = 3;
      offer(16'h9C3E);
      wait_idle();
      check_eq("held_planes", plane_log.size(), 4);
      check_eq("held_fd", fd_count - fd0, 1);
      done_len = 1;

      // Transfer on the last consuming edge with pending empty: gap, then plane 0, no idle
      offer(16'h0FA3);
      begin
         int t = 0;
         while (!(pe_done_i && pe_last_o && pe_valid_o) && t < 1000) begin
            @(negedge clk);
            #1;
            t++;
         end
         if (t >= 1000) check_eq("edge_case_timeout", 1, 0);
      end
      b_frame = 16'h3C96;
      acts_valid_i = 1'b1;
      acts_data_i  = b_frame;
      @(posedge clk);
      #2;
      acts_valid_i = 1'b0;
      check_eq("edge_gap_valid", pe_valid_o, 0);
      check_eq("edge_fd", frame_done_o, 1);
      @(posedge clk);
      #2;
      check_eq("edge_plane0_valid", pe_valid_o, 1);
      check_eq("edge_plane0_idx", pe_bit_idx_o, 0);
      check_eq("edge_plane0_data", pe_data_o, plane_of(b_frame, 0));
      @(negedge clk);
      wait_idle();

      // Reset during plane 2
      fd0 = fd_count;
      offer(16'h0FA3);
      wait_plane(2);
      #2;
      nrst = 1'b0;
      model_clear();
      #1;
      check_eq("mid_rst_valid", pe_valid_o, 0);
      check_eq("mid_rst_data", pe_data_o, 0);
      check_eq("mid_rst_idx", pe_bit_idx_o, 0);
      check_eq("mid_rst_last", pe_last_o, 0);
      check_eq("mid_rst_fd", frame_done_o, 0);
      check_eq("mid_rst_ready", acts_ready_o, 0);
      repeat (2) @(negedge clk);
      nrst = 1'b1;
      @(posedge clk);
      #2;
      check_eq("mid_rst_ready_after", acts_ready_o, 1);
      repeat (8) @(negedge clk);
      check_eq("mid_rst_no_fd", fd_count - fd0, 0);

      // Randomized traffic
      plane_log.delete(); fd0 = fd_count;
      for (int k = 0; k < 25; k++) begin
         pe_delay = int'($urandom_range(1, 8));
         done_len = int'($urandom_range(1, 2));
         offer(W'($urandom));
         repeat ($urandom_range(0, 6)) @(negedge clk);
      end
      wait_idle();
      check_eq("rand_fd", fd_count - fd0, 25);
      check_eq("rand_planes", plane_log.size(), 100);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
